unaligned_mem_port: RTL and testbench

Byte-addressed, unaligned load/store port over a word-organised synchronous RAM. Accepts one request at a time (byte, halfword or word; read or write) at any byte address. A request that straddles a word boundary is split into two word accesses, and writes are done as read-modify-write. Sits between lab-level datapath/test tops (switch-driven address, 7-segment display) and the block RAM, and supersedes fixed two-read halfword fetch logic.

---
 rtl/mem_port_defs.sv | 25 ++
 rtl/word_ram.sv | 30 +++
 rtl/unaligned_mem_port.sv | 163 ++++++++++++++++
 tb/tb_unaligned_mem_port.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_defs.sv
// Shared definitions for the unaligned memory port: FSM states, size codes, word geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_port_defs;

    // Access sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        RESP = 3'd5
    } state_t;

    // req_size encodings (access length = 2^size bytes).
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Default word geometry: 32-bit words.
    localparam int BYTES = 4;
    localparam int OFF_W = $clog2(BYTES);

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word RAM, read-first; contents are not reset.
// Latency: dout holds the addressed word's pre-write value one cycle after addr is sampled.
// Backpressure: none; one access per cycle.
//   clk  - clock
//   we   - write enable, sampled at posedge
//   addr - word address, sampled at posedge
//   din  - write data
//   dout - registered read data (old value on a write)
module word_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/unaligned_mem_port.sv
// Big-endian byte-addressed load/store port over word RAM; boundary-crossing accesses split in two, writes are RMW.
// Latency: read 2 (3 if spanning), write 3 (5 if spanning) cycles from acceptance to resp_valid.
// Backpressure: req_ready low while an access is in flight; resp_valid is a one-cycle pulse with no stall.
//   req_valid/req_ready/req_we/req_size/req_addr/req_wdata - request handshake and fields
//   resp_valid/resp_rdata - completion pulse and right-justified, zero-extended read data
//   busy - inverse of req_ready
module unaligned_mem_port
    import mem_port_defs::*;
#(
    parameter int DATA_W = BYTES * 8,
    parameter int ADDR_W = 8,
    parameter int SIZE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [SIZE_W-1:0] req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
);

    localparam int NB    = DATA_W / 8;
    localparam int OW    = $clog2(NB);
    localparam int WA_W  = ADDR_W - OW;
    localparam int DEPTH = 1 << WA_W;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [SIZE_W-1:0] r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] da, db;

    logic [WA_W-1:0]   r_wa;
    logic [OW-1:0]     r_off;
    logic [OW:0]       nbytes;
    logic [OW:0]       pad;
    logic              span;

    logic [2*DATA_W-1:0] pair;
    logic [2*DATA_W-1:0] merged;
    logic [DATA_W-1:0]   rd_top;
    logic [DATA_W-1:0]   rd_word;

    logic              ram_we;
    logic [WA_W-1:0]   ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    assign r_wa  = r_addr[ADDR_W-1:OW];
    assign r_off = r_addr[OW-1:0];
    assign pair  = {da, db};

    // Sizes beyond a full word collapse to a full word.
    always_comb begin
        nbytes = (OW+1)'(NB);
        if (int'(r_size) < OW) begin
            nbytes = (OW+1)'(1) << r_size;
        end
    end

    assign pad  = (OW+1)'(NB) - nbytes;
    assign span = ({1'b0, r_off} + nbytes) > (OW+1)'(NB);

    // Read path: window of DATA_W bits starting at byte off of {da,db},
    // then drop the unrequested low bytes so the result is right-justified.
    always_comb begin
        int msb;
        msb     = 2*DATA_W - 1 - 8*int'(r_off);
        rd_top  = pair[msb -: DATA_W];
        rd_word = rd_top >> {pad, 3'b000};
    end

    // Write path: overlay the n right-justified wdata bytes onto {da,db}
    // starting at byte off (byte 0 = most significant byte of da).
    always_comb begin
        int k;
        merged = pair;
        k      = 0;
        for (int i = 0; i < 2*NB; i++) begin
            k = i - int'(r_off);
            if (k >= 0 && k < int'(nbytes)) begin
                merged[(2*NB-1-i)*8 +: 8] = r_wdata[(int'(nbytes)-1-k)*8 +: 8];
            end
        end
    end

    // Next state and RAM control. The second word address (wa+1) wraps
    // naturally through the WA_W-bit adder.
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = r_wa + WA_W'(1);
        ram_din   = merged[2*DATA_W-1 -: DATA_W];
        case (state)
            IDLE: begin
                ram_addr = req_addr[ADDR_W-1:OW];
                if (req_valid) begin
                    state_nxt = RD_A;
                end
            end
            RD_A:    state_nxt = span ? RD_B : (r_we ? WR_A : RESP);
            RD_B:    state_nxt = r_we ? WR_A : RESP;
            WR_A: begin
                ram_addr  = r_wa;
                ram_we    = 1'b1;
                state_nxt = span ? WR_B : RESP;
            end
            WR_B: begin
                ram_we    = 1'b1;
                ram_din   = merged[DATA_W-1:0];
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_wdata <= '0;
            da      <= '0;
            db      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_size  <= req_size;
                r_wdata <= req_wdata;
            end
            if (state == RD_A) da <= ram_dout;
            if (state == RD_B) db <= ram_dout;
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = !req_ready;
    assign resp_valid = (state == RESP);
    assign resp_rdata = (state == RESP && !r_we) ? rd_word : '0;

    word_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (WA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

endmodule

// File: tb/tb_unaligned_mem_port.sv
// Scoreboard bench for unaligned_mem_port (DATA_W=32, ADDR_W=8).
// Latency: expected response cycle is pushed at acceptance and compared when resp_valid fires.
// Backpressure: request held until req_ready; response taken in its pulse cycle.
module tb_unaligned_mem_port;
    import mem_port_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [7:0]  req_addr = 8'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;

    unaligned_mem_port #(.DATA_W(32), .ADDR_W(8), .SIZE_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    int          due_q [$];
    int          t0_q  [$];
    string       tag_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: ready must stay low while an access is in flight,
    // and every pulse must match the head of the scoreboard in data and cycle.
    always @(negedge clk) begin
        if (t0_q.size() > 0 && cyc > t0_q[0] && cyc < due_q[0]) begin
            chk("busy_ready_low", {31'd0, req_ready}, 32'd0);
        end
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_resp", 32'd1, 32'd0);
            end else begin
                string tg;
                tg = tag_q.pop_front();
                chk({tg, "_data"}, resp_rdata, exp_q.pop_front());
                chk({tg, "_cycle"}, cyc, due_q.pop_front());
                void'(t0_q.pop_front());
            end
        end
    end

    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp, input int lat, output int t0);
        int budget;
        budget = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        t0 = cyc;
        if (!req_ready) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            exp_q.push_back(exp);
            due_q.push_back(cyc + lat);
            t0_q.push_back(cyc);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            chk("resp_timeout", 32'd0, 32'd1);
            exp_q.delete();
            due_q.delete();
            t0_q.delete();
            tag_q.delete();
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input int lat);
        int t0;
        issue(tag, we, size, addr, wdata, exp, lat, t0);
        wait_idle();
    endtask

    initial begin
        int ta, tb;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Preload with aligned word writes (no span: 3 cycles).
        txn("pre_w0",  1'b1, SZ_WORD, 8'h00, 32'h11223344, 32'd0, 3);
        txn("pre_w1",  1'b1, SZ_WORD, 8'h04, 32'h55667788, 32'd0, 3);
        txn("pre_w2",  1'b1, SZ_WORD, 8'h08, 32'h99AABBCC, 32'd0, 3);
        txn("pre_w3",  1'b1, SZ_WORD, 8'h0C, 32'h0D0E0F10, 32'd0, 3);
        txn("pre_w63", 1'b1, SZ_WORD, 8'hFC, 32'hA0B0C0D0, 32'd0, 3);

        // Reads: aligned-within-word, spanning, byte, word spanning, wrap.
        txn("rd_half1",  1'b0, SZ_HALF, 8'h01, 32'd0, 32'h00002233, 2);
        txn("rd_half3",  1'b0, SZ_HALF, 8'h03, 32'd0, 32'h00004455, 3);
        txn("rd_byte7",  1'b0, SZ_BYTE, 8'h07, 32'd0, 32'h00000088, 2);
        txn("rd_word6",  1'b0, SZ_WORD, 8'h06, 32'd0, 32'h778899AA, 3);
        txn("rd_wordFE", 1'b0, SZ_WORD, 8'hFE, 32'd0, 32'hC0D01122, 3);

        // Spanning word write, then readback of both words.
        txn("wr_word2", 1'b1, SZ_WORD, 8'h02, 32'hDEADBEEF, 32'd0, 5);
        txn("rb_w0",    1'b0, SZ_WORD, 8'h00, 32'd0, 32'h1122DEAD, 2);
        txn("rb_w1",    1'b0, SZ_WORD, 8'h04, 32'd0, 32'hBEEF7788, 2);

        // Wrapping halfword write across last word and word 0.
        txn("wr_halfFF", 1'b1, SZ_HALF, 8'hFF, 32'h0000CAFE, 32'd0, 5);
        txn("rb_w63",    1'b0, SZ_WORD, 8'hFC, 32'd0, 32'hA0B0C0CA, 2);
        txn("rb_w0b",    1'b0, SZ_WORD, 8'h00, 32'd0, 32'hFE22DEAD, 2);

        // Oversized size code clamps to a word; byte write inside a word.
        txn("rd_clamp", 1'b0, 2'd3,    8'h04, 32'd0, 32'hBEEF7788, 2);
        txn("wr_byte5", 1'b1, SZ_BYTE, 8'h05, 32'hFFFFFF5A, 32'd0, 3);
        txn("rb_w1b",   1'b0, SZ_WORD, 8'h04, 32'd0, 32'hBE5A7788, 2);

        // Reset during RD_B of a spanning write: no response, memory untouched.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_WORD;
        req_addr  = 8'h0A;
        req_wdata = 32'h01020304;
        chk("rstmid_pre_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_busy_rdb", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_resp", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstmid_ready_after", {31'd0, req_ready}, 32'd1);
        txn("rstmid_w2", 1'b0, SZ_WORD, 8'h08, 32'd0, 32'h99AABBCC, 2);
        txn("rstmid_w3", 1'b0, SZ_WORD, 8'h0C, 32'd0, 32'h0D0E0F10, 2);

        // Request held valid during a busy spanning write is taken right after RESP.
        issue("hold_a", 1'b1, SZ_HALF, 8'h07, 32'h0000ABCD, 32'd0, 5, ta);
        issue("hold_b", 1'b0, SZ_WORD, 8'h04, 32'd0, 32'hBE5A77AB, 2, tb);
        chk("hold_accept_cycle", tb, ta + 6);
        wait_idle();
        txn("hold_rb_w2", 1'b0, SZ_WORD, 8'h08, 32'd0, 32'hCDAABBCC, 2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
